// File: rtl/mealy_seq_pkg.sv
// Shared types and parameter limits for the serial pattern detector.
package mealy_seq_pkg;

  typedef enum logic {
    S_UNARMED = 1'b0,
    S_ARMED   = 1'b1
  } state_e;

  localparam int unsigned PAT_LEN_MIN = 2;
  localparam int unsigned PAT_LEN_MAX = 32;
  localparam int unsigned CNT_W_MIN   = 1;

  function automatic bit pat_len_ok(input int unsigned n);
    return (n >= PAT_LEN_MIN) && (n <= PAT_LEN_MAX);
  endfunction

endpackage

// File: rtl/mealy_seq_detect_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/mealy_seq_detect.sv
// Serial bit-pattern detector: loadable pattern, overlap/non-overlap mode,
// Mealy or registered match output, saturating match counter.
module mealy_seq_detect
  import mealy_seq_pkg::*;
#(
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned REG_OUT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  localparam int unsigned HW = PAT_LEN - 1;
  localparam int unsigned FW = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);

  if (!pat_len_ok(PAT_LEN)) begin : g_bad_pat_len
    $error("mealy_seq_detect: PAT_LEN out of range");
  end
  if (CNT_W < CNT_W_MIN) begin : g_bad_cnt_w
    $error("mealy_seq_detect: CNT_W too small");
  end

  state_e             state_q, state_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic               ovl_q, ovl_d;
  logic [HW-1:0]      hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               hit;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    hit     = 1'b0;

    if (load) begin
      state_d = S_ARMED;
      pat_d   = pattern;
      ovl_d   = overlap;
      hist_d  = '0;
      fill_d  = '0;
    end else if ((state_q == S_ARMED) && in_valid) begin
      hit    = (fill_q == FILL_MAX) && ({hist_q, in_bit} == pat_q);
      hist_d = HW'({hist_q, in_bit});
      // Non-overlap restarts the fill so bits of a completed match are not reused.
      if (hit && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_UNARMED;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (load),
    .inc  (hit),
    .q    (match_count)
  );

  if (REG_OUT != 0) begin : g_reg_out
    logic match_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        match_q <= 1'b0;
      end else begin
        match_q <= hit;
      end
    end
    assign match = match_q;
  end else begin : g_mealy_out
    assign match = hit;
  end

  assign armed = (state_q == S_ARMED);

endmodule

// File: doc/mealy_seq_detect.md
MEALY_SEQ_DETECT -- requirements
Module: mealy_seq_detect

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4, pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 8, match-counter width, minimum 1.
REQ-003 SHALL have parameter REG_OUT, default 0; 0 = Mealy match output, 1 = match output registered one cycle later.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port load  input  1  capture pattern and mode, clear history and count, arm the detector.
REQ-007 SHALL have port pattern  input  PAT_LEN  target sequence; MSB is the first bit received.
REQ-008 SHALL have port overlap  input  1  mode sampled on load; 1 = overlapping matches, 0 = non-overlapping.
REQ-009 SHALL have port in_valid  input  1  in_bit is consumed this cycle.
REQ-010 SHALL have port in_bit  input  1  serial data bit.
REQ-011 SHALL have port match  output  1  pattern completed by the consumed bit.
REQ-012 SHALL have port match_count  output  CNT_W  saturating count of matches since the last load.
REQ-013 SHALL have port armed  output  1  high when the detector is in S_ARMED.

Function
REQ-014 SHALL implement a control FSM with states S_UNARMED and S_ARMED; load moves either state to S_ARMED; no other transition exists except reset.
REQ-015 On load, SHALL latch pattern into pat_q and overlap into ovl_q, clear the history register and the fill counter, and clear match_count, all in the same edge.
REQ-016 When load and in_valid are high in the same cycle, load SHALL win: the bit is dropped, and match is 0 that cycle.
REQ-017 In S_UNARMED, in_valid SHALL be ignored, and match SHALL be 0.
REQ-018 In S_ARMED with in_valid=1, the history SHALL shift in in_bit at the LSB, and the fill counter SHALL increment, saturating at PAT_LEN-1.
REQ-019 A hit SHALL be defined as: S_ARMED, in_valid=1, load=0, fill counter = PAT_LEN-1, and {history[PAT_LEN-2:0], in_bit} = pat_q.
REQ-020 With REG_OUT=0, match SHALL equal hit combinationally in the same cycle.
REQ-021 With REG_OUT=1, match SHALL be hit delayed by exactly one clock.
REQ-022 On a hit with ovl_q=1, the history and fill counter SHALL update normally.
REQ-023 On a hit with ovl_q=0, the fill counter SHALL be cleared to 0 so that no completed bit is reused.
REQ-024 match_count SHALL increment by 1 on each hit, and SHALL hold at all-ones once saturated.
REQ-025 Cycles with in_valid=0 SHALL leave history, fill counter and match_count unchanged.
REQ-026 Changes on pattern or overlap while not loading SHALL have no effect.

Reset
REQ-027 reset SHALL take priority over load.
REQ-028 reset SHALL set: state S_UNARMED, history 0, fill counter 0, pat_q 0, ovl_q 0, match_count 0, registered match 0.
REQ-029 After reset, outputs SHALL be match=0, match_count=0, armed=0.
REQ-030 Reset mid-pattern SHALL discard all partial progress; a later load is required before any match.

Structure
REQ-031 Package mealy_seq_pkg SHALL hold the state enum typedef (S_UNARMED, S_ARMED).
REQ-032 Package mealy_seq_pkg SHALL hold the PAT_LEN legal-range constants.
REQ-033 Saturating counter SHALL be a sub-module sat_counter (parameter W; inputs clk, reset, clr, inc; output q).

Verification (PAT_LEN=4, pattern=4'b1011)
REQ-034 Overlap mode, REG_OUT=0: load, then bits 1,0,1,1,0,1,1 -> match high on bit 4 and bit 7; match_count=2.
REQ-035 Non-overlap mode, same stream -> match high on bit 4 only; match_count=1.
REQ-036 Bits 1,0 then two in_valid=0 cycles then 1,1 -> match on the final bit; idle cycles preserve state.
REQ-037 Bits driven before any load -> match=0, armed=0; load concurrent with a valid bit drops that bit.
REQ-038 CNT_W=2, overlap mode, stream 1011 repeated five times -> match_count reaches 3 and holds; REG_OUT=1 run shows each match one cycle late.
REQ-039 Bits 1,0,1 then reset, then load, then bit 1 -> no match; armed=0 until the load.
